// File: rtl/fnd_scan_piano.sv
// Scanned 7-segment driver: latches the pressed note, holds it after release, multiplexes N digits.
// Latency: note_valid one cycle after a valid key; glyphs change only at the next digit-slot boundary.
// Backpressure: none; free-running scan, inputs sampled every cycle.
module fnd_scan_piano #(
  parameter int N_DIGIT        = 4,
  parameter int SCAN_DIV       = 10000,
  parameter int BLANK_CYC      = 16,
  parameter int HOLD_CYC       = 5000000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         sel,
  input  logic               flat,
  input  logic               octave,
  output logic [6:0]         seg_out,
  output logic               dp_out,
  output logic [N_DIGIT-1:0] com_out,
  output logic               note_valid
);

  localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW  = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
  localparam int HCW = $clog2(HOLD_CYC + 1);

  localparam logic [PCW-1:0] PRE_TC   = PCW'(SCAN_DIV - 1);
  localparam logic [PCW-1:0] PRE_BLK  = PCW'(BLANK_CYC);
  localparam logic [DW-1:0]  DIG_LAST = DW'(N_DIGIT - 1);
  localparam logic [HCW-1:0] HOLD_LD  = HCW'(HOLD_CYC);

  logic [PCW-1:0]     pre_cnt, pre_nxt;
  logic [DW-1:0]      dig_idx, dig_nxt;
  logic               pre_tc;
  logic [HCW-1:0]     hold_cnt;
  logic               released;
  logic [2:0]         tone_q;
  logic               flat_q, oct_q;
  logic               key_vld;
  logic [6:0]         tone_glyph, dig_glyph;
  logic               dp_nxt;
  logic [N_DIGIT-1:0] com_oh;

  // Codes 1..7 are keys; 0 and 8..15 mean nothing pressed.
  assign key_vld = (sel[3] == 1'b0) && (sel[2:0] != 3'd0);

  // Note latch and post-release hold countdown; a fresh key always wins over expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tone_q     <= 3'd0;
      flat_q     <= 1'b0;
      oct_q      <= 1'b0;
      note_valid <= 1'b0;
      released   <= 1'b0;
      hold_cnt   <= '0;
    end else if (key_vld) begin
      tone_q     <= sel[2:0];
      flat_q     <= flat;
      oct_q      <= octave;
      note_valid <= 1'b1;
      released   <= 1'b0;
      hold_cnt   <= HOLD_LD;
    end else if (note_valid) begin
      released <= 1'b1;
      hold_cnt <= hold_cnt - 1'b1;
      if (hold_cnt == HCW'(1)) begin
        note_valid <= 1'b0;
        tone_q     <= 3'd0;
        released   <= 1'b0;
      end
    end
  end

  // Next scan position and the glyph/common pattern that position will show.
  always_comb begin
    pre_tc  = (pre_cnt == PRE_TC);
    pre_nxt = pre_tc ? '0 : pre_cnt + 1'b1;
    dig_nxt = dig_idx;
    if (pre_tc) begin
      dig_nxt = (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
    end

    case (tone_q)
      3'd1:    tone_glyph = 7'h39;
      3'd2:    tone_glyph = 7'h5E;
      3'd3:    tone_glyph = 7'h79;
      3'd4:    tone_glyph = 7'h71;
      3'd5:    tone_glyph = 7'h3D;
      3'd6:    tone_glyph = 7'h77;
      3'd7:    tone_glyph = 7'h7C;
      default: tone_glyph = 7'h00;
    endcase

    dig_glyph = 7'h00;
    dp_nxt    = 1'b0;
    if (note_valid) begin
      case (int'(dig_nxt))
        0: begin
          dig_glyph = tone_glyph;
          dp_nxt    = released;
        end
        1:       dig_glyph = flat_q ? 7'h7C : 7'h00;
        2:       dig_glyph = oct_q ? 7'h6D : 7'h66;
        default: dig_glyph = 7'h00;
      endcase
    end

    // Commons stay dark for the first BLANK_CYC cycles of a slot to stop ghosting.
    com_oh = (pre_nxt >= PRE_BLK) ? (N_DIGIT'(1) << dig_nxt) : '0;
  end

  // Scan counters and registered display outputs; segments only change at a slot boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      dig_idx <= '0;
      seg_out <= {7{SEG_ACTIVE_LOW}};
      dp_out  <= SEG_ACTIVE_LOW;
      com_out <= {N_DIGIT{COM_ACTIVE_LOW}};
    end else begin
      pre_cnt <= pre_nxt;
      dig_idx <= dig_nxt;
      com_out <= COM_ACTIVE_LOW ? ~com_oh : com_oh;
      if (pre_tc) begin
        seg_out <= SEG_ACTIVE_LOW ? ~dig_glyph : dig_glyph;
        dp_out  <= dp_nxt ^ SEG_ACTIVE_LOW;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_piano.sv
// Bench for fnd_scan_piano: directed test-plan sequences plus randomized key traffic.
// Expected outputs come from a cycle-counting behavioural model of the display.
// All outputs compared at the falling edge, every cycle.
module tb_fnd_scan_piano;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int HC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    sel;
  logic          flat;
  logic          octave;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [ND-1:0] com_out;
  logic          note_valid;

  fnd_scan_piano #(
    .N_DIGIT(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .HOLD_CYC(HC),
    .SEG_ACTIVE_LOW(1'b0), .COM_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .flat(flat), .octave(octave),
    .seg_out(seg_out), .dp_out(dp_out), .com_out(com_out), .note_valid(note_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: edges since reset release, latched note, hold remaining, per-slot expectations.
  int         t;
  bit         m_valid, m_rel, m_flat, m_oct;
  int         m_tone, m_hold;
  logic [6:0] e_seg;
  bit         e_dp;
  logic [6:0] tone_tab [0:7] = '{7'h00, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h77, 7'h7C};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, act, exp, t, $time);
    end
  endtask

  function automatic logic [6:0] model_digit(input int d);
    if (!m_valid) return 7'h00;
    case (d)
      0:       return tone_tab[m_tone];
      1:       return m_flat ? 7'h7C : 7'h00;
      2:       return m_oct ? 7'h6D : 7'h66;
      default: return 7'h00;
    endcase
  endfunction

  task automatic model_reset();
    t = 0; m_valid = 0; m_rel = 0; m_flat = 0; m_oct = 0;
    m_tone = 0; m_hold = 0; e_seg = 7'h00; e_dp = 0;
  endtask

  // One clock: drive inputs, advance model at the rising edge, compare at the falling edge.
  task automatic cycle(input logic [3:0] s, input logic f, input logic o);
    int         slot;
    logic [3:0] oh;
    logic [3:0] e_com;
    sel = s; flat = f; octave = o;
    @(posedge clk);
    t++;
    if (t % SD == 0) begin
      slot  = (t / SD) % ND;
      e_seg = model_digit(slot);
      e_dp  = (slot == 0) && m_valid && m_rel;
    end
    if (s >= 1 && s <= 7) begin
      m_valid = 1; m_tone = s; m_flat = f; m_oct = o; m_hold = HC; m_rel = 0;
    end else if (m_valid) begin
      m_rel = 1;
      m_hold--;
      if (m_hold == 0) begin
        m_valid = 0; m_tone = 0; m_rel = 0;
      end
    end
    slot  = (t / SD) % ND;
    oh    = 4'b0001 << slot;
    e_com = ((t % SD) >= BC) ? ~oh : 4'hF;
    @(negedge clk);
    chk("com_out", com_out, e_com);
    chk("seg_out", seg_out, e_seg);
    chk("dp_out", dp_out, e_dp);
    chk("note_valid", note_valid, m_valid);
  endtask

  task automatic run(input int n, input logic [3:0] s, input logic f, input logic o);
    for (int i = 0; i < n; i++) cycle(s, f, o);
  endtask

  // Asynchronous reset between edges: outputs must go idle with no clock, then restart cleanly.
  task automatic mid_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_seg", seg_out, 7'h00);
    chk("rst_com", com_out, 4'hF);
    chk("rst_dp", dp_out, 1'b0);
    chk("rst_nv", note_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_com", com_out, 4'hF);
    chk("rst_hold_nv", note_valid, 1'b0);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic random_traffic(input int n_runs);
    logic [3:0] s;
    for (int r = 0; r < n_runs; r++) begin
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) s = 4'd0;
      for (int k = 0; k < int'($urandom_range(1, 12)); k++)
        cycle(s, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; sel = 4'd0; flat = 1'b0; octave = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("init_seg", seg_out, 7'h00);
    chk("init_com", com_out, 4'hF);
    chk("init_nv", note_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    run(20, 4'd0, 1'b0, 1'b0);       // idle scan
    run(20, 4'd3, 1'b1, 1'b1);       // E flat, octave 5
    run(14, 4'd0, 1'b0, 1'b0);       // release and expiry
    run(10, 4'd3, 1'b1, 1'b1);
    run(5, 4'd0, 1'b1, 1'b0);        // partial hold, modifiers ignored
    run(10, 4'd6, 1'b0, 1'b0);       // re-press with different note
    run(12, 4'd0, 1'b0, 1'b0);
    run(5, 4'd2, 1'b0, 1'b1);
    run(12, 4'd9, 1'b1, 1'b0);       // invalid code acts as release
    run(7, 4'd5, 1'b1, 1'b0);
    run(HC - 1, 4'd0, 1'b0, 1'b0);
    run(3, 4'd7, 1'b0, 1'b1);        // press at the would-be expiry cycle
    run(6, 4'd0, 1'b0, 1'b0);
    mid_reset();                     // reset in the middle of a hold
    run(20, 4'd0, 1'b0, 1'b0);

    random_traffic(150);
    mid_reset();
    random_traffic(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
